// File: rtl/ro_deserializer.sv
// ---------------------------------------------------------------------------
// ro_deserializer
//
// Recovers per-channel samples from the time-multiplexed readout lines of
// NCH readout cores. The cores share a Gray counter clocked by clk_master;
// on each edge exactly one Gray bit toggles, and the core owning that bit
// drives rd_eve/rd_pol during the following clk_master high phase. This
// block mirrors the Gray counter with a binary counter, works out which
// channel owns each slot, captures the shared lines on the falling edge and
// presents the sample one cycle after the decode edge.
//
// Ports:
//   clk_master  in   master clock (same clock as the cores' Gray counter)
//   rstb        in   asynchronous active-low reset (same net as the counter)
//   run         in   slot tracking enable
//   clr         in   synchronous clear of eve_seen/pol_seen
//   rd_eve      in   shared event readout line
//   rd_pol      in   shared polarity-event readout line
//   slot_valid  out  one-cycle strobe: slot_idx/slot_eve/slot_pol are fresh
//   slot_idx    out  channel index of the presented sample
//   slot_eve    out  captured rd_eve sample
//   slot_pol    out  captured rd_pol sample
//   eve_seen    out  sticky per-channel event flags
//   pol_seen    out  sticky per-channel polarity-event flags
//   frame_done  out  one-cycle strobe for the idle slot closing each frame
// ---------------------------------------------------------------------------
module ro_deserializer #(
    parameter int NCH = 8
) (
    input  logic                    clk_master,
    input  logic                    rstb,
    input  logic                    run,
    input  logic                    clr,
    input  logic                    rd_eve,
    input  logic                    rd_pol,
    output logic                    slot_valid,
    output logic [$clog2(NCH)-1:0]  slot_idx,
    output logic                    slot_eve,
    output logic                    slot_pol,
    output logic [NCH-1:0]          eve_seen,
    output logic [NCH-1:0]          pol_seen,
    output logic                    frame_done
);

    localparam int IW = $clog2(NCH);
    // One extra code point is needed: a trailing-ones count of NCH means idle.
    localparam int KW = $clog2(NCH + 1);

    // Number of trailing ones of v: the index of the Gray bit toggling when
    // the mirrored binary count steps from v to v+1.
    function automatic logic [KW-1:0] trail_ones(input logic [NCH-1:0] v);
        logic [KW-1:0] n_ones;
        logic          stop;
        n_ones = {KW{1'b0}};
        stop   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!stop && v[i]) begin
                n_ones = n_ones + {{(KW-1){1'b0}}, 1'b1};
            end else begin
                stop = 1'b1;
            end
        end
        return n_ones;
    endfunction

    // Slot counter and decode stage (rising edge)
    logic [NCH-1:0] cnt_q, cnt_d;
    logic           dec_pend_q, dec_pend_d;
    logic           dec_idle_q, dec_idle_d;
    logic [IW-1:0]  dec_k_q, dec_k_d;
    logic [KW-1:0]  trail_s;

    // Capture stage (falling edge)
    logic           cap_valid_q;
    logic           cap_idle_q;
    logic [IW-1:0]  cap_k_q;
    logic           cap_eve_q;
    logic           cap_pol_q;

    // Presentation stage (rising edge)
    logic           slot_valid_q, slot_valid_d;
    logic [IW-1:0]  slot_idx_q, slot_idx_d;
    logic           slot_eve_q, slot_eve_d;
    logic           slot_pol_q, slot_pol_d;
    logic           frame_done_q, frame_done_d;
    logic [NCH-1:0] eve_seen_q, eve_seen_d;
    logic [NCH-1:0] pol_seen_q, pol_seen_d;
    logic           present_act_s;
    logic [NCH-1:0] chan_mask_s;

    assign trail_s = trail_ones(cnt_q);

    // Next-state for the slot counter and the decode of the slot owner
    always_comb begin
        cnt_d      = cnt_q;
        dec_pend_d = 1'b0;
        dec_idle_d = dec_idle_q;
        dec_k_d    = dec_k_q;
        if (run) begin
            cnt_d      = cnt_q + {{(NCH-1){1'b0}}, 1'b1};
            dec_pend_d = 1'b1;
            // All ones: the extra frame bit toggles, no channel owns the slot.
            dec_idle_d = &cnt_q;
            dec_k_d    = IW'(trail_s);
        end else begin
            cnt_d      = cnt_q;
            dec_pend_d = 1'b0;
        end
    end

    // Slot counter and decode registers
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cnt_q      <= {NCH{1'b0}};
            dec_pend_q <= 1'b0;
            dec_idle_q <= 1'b0;
            dec_k_q    <= {IW{1'b0}};
        end else begin
            cnt_q      <= cnt_d;
            dec_pend_q <= dec_pend_d;
            dec_idle_q <= dec_idle_d;
            dec_k_q    <= dec_k_d;
        end
    end

    // Falling-edge capture of the readout lines at the end of the drive window.
    // dec_pend_q drops after a run=0 edge, so nothing new is captured then.
    always_ff @(negedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cap_valid_q <= 1'b0;
            cap_idle_q  <= 1'b0;
            cap_k_q     <= {IW{1'b0}};
            cap_eve_q   <= 1'b0;
            cap_pol_q   <= 1'b0;
        end else begin
            cap_valid_q <= dec_pend_q;
            cap_idle_q  <= dec_idle_q;
            cap_k_q     <= dec_k_q;
            cap_eve_q   <= rd_eve;
            cap_pol_q   <= rd_pol;
        end
    end

    assign present_act_s = cap_valid_q & ~cap_idle_q;
    assign chan_mask_s   = {{(NCH-1){1'b0}}, 1'b1} << cap_k_q;

    // Presentation of the captured sample and sticky flag update
    always_comb begin
        slot_valid_d = present_act_s;
        frame_done_d = cap_valid_q & cap_idle_q;
        slot_idx_d   = slot_idx_q;
        slot_eve_d   = slot_eve_q;
        slot_pol_d   = slot_pol_q;
        eve_seen_d   = eve_seen_q;
        pol_seen_d   = pol_seen_q;
        if (present_act_s) begin
            slot_idx_d = cap_k_q;
            slot_eve_d = cap_eve_q;
            slot_pol_d = cap_pol_q;
        end else begin
            slot_idx_d = slot_idx_q;
            slot_eve_d = slot_eve_q;
            slot_pol_d = slot_pol_q;
        end
        // clr wins over a simultaneous set; that edge's sample is dropped.
        if (clr) begin
            eve_seen_d = {NCH{1'b0}};
            pol_seen_d = {NCH{1'b0}};
        end else if (present_act_s) begin
            eve_seen_d = eve_seen_q | (chan_mask_s & {NCH{cap_eve_q}});
            pol_seen_d = pol_seen_q | (chan_mask_s & {NCH{cap_pol_q}});
        end else begin
            eve_seen_d = eve_seen_q;
            pol_seen_d = pol_seen_q;
        end
    end

    // Presentation registers
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            slot_valid_q <= 1'b0;
            slot_idx_q   <= {IW{1'b0}};
            slot_eve_q   <= 1'b0;
            slot_pol_q   <= 1'b0;
            frame_done_q <= 1'b0;
            eve_seen_q   <= {NCH{1'b0}};
            pol_seen_q   <= {NCH{1'b0}};
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_idx_q   <= slot_idx_d;
            slot_eve_q   <= slot_eve_d;
            slot_pol_q   <= slot_pol_d;
            frame_done_q <= frame_done_d;
            eve_seen_q   <= eve_seen_d;
            pol_seen_q   <= pol_seen_d;
        end
    end

    assign slot_valid = slot_valid_q;
    assign slot_idx   = slot_idx_q;
    assign slot_eve   = slot_eve_q;
    assign slot_pol   = slot_pol_q;
    assign frame_done = frame_done_q;
    assign eve_seen   = eve_seen_q;
    assign pol_seen   = pol_seen_q;

endmodule

// File: tb/tb_ro_deserializer.sv
// ---------------------------------------------------------------------------
// tb_ro_deserializer
//
// Drives an NCH=8 and an NCH=2 deserializer side by side from a bench-side
// Gray counter model with per-channel readout drivers. Each decode edge
// pushes the expected presented sample into a scoreboard queue; it is popped
// and compared on the edge where the DUT must present it.
// ---------------------------------------------------------------------------
module tb_ro_deserializer;

    typedef struct {
        int cyc;
        int inst;
        bit idle;
        int k;
        bit eve;
        bit pol;
    } item_t;

    logic       clk_master = 1'b0;
    logic       rstb = 1'b0;
    logic       run = 1'b1;
    logic       clr = 1'b0;
    logic [1:0] rde = 2'b00;
    logic [1:0] rdp = 2'b00;

    logic       sv8, se8, sp8, fd8;
    logic [2:0] idx8;
    logic [7:0] es8, ps8;
    logic       sv2, se2, sp2, fd2;
    logic [0:0] idx2;
    logic [1:0] es2, ps2;

    ro_deserializer #(.NCH(8)) dut8 (
        .clk_master(clk_master), .rstb(rstb), .run(run), .clr(clr),
        .rd_eve(rde[0]), .rd_pol(rdp[0]),
        .slot_valid(sv8), .slot_idx(idx8), .slot_eve(se8), .slot_pol(sp8),
        .eve_seen(es8), .pol_seen(ps8), .frame_done(fd8)
    );

    ro_deserializer #(.NCH(2)) dut2 (
        .clk_master(clk_master), .rstb(rstb), .run(run), .clr(clr),
        .rd_eve(rde[1]), .rd_pol(rdp[1]),
        .slot_valid(sv2), .slot_idx(idx2), .slot_eve(se2), .slot_pol(sp2),
        .eve_seen(es2), .pol_seen(ps2), .frame_done(fd2)
    );

    always #5 clk_master = ~clk_master;

    // Uniform per-instance views of the DUT outputs
    logic       o_valid [2];
    logic       o_done  [2];
    logic [2:0] o_idx   [2];
    logic       o_eve   [2];
    logic       o_pol   [2];
    logic [7:0] o_es    [2];
    logic [7:0] o_ps    [2];
    assign o_valid[0] = sv8;  assign o_valid[1] = sv2;
    assign o_done[0]  = fd8;  assign o_done[1]  = fd2;
    assign o_idx[0]   = idx8; assign o_idx[1]   = {2'b00, idx2};
    assign o_eve[0]   = se8;  assign o_eve[1]   = se2;
    assign o_pol[0]   = sp8;  assign o_pol[1]   = sp2;
    assign o_es[0]    = es8;  assign o_es[1]    = {6'b000000, es2};
    assign o_ps[0]    = ps8;  assign o_ps[1]    = {6'b000000, ps2};

    // Bench model state
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         nch [2] = '{8, 2};
    int         b   [2] = '{0, 0};
    int         fcount [2] = '{0, 0};
    logic [7:0] emask [2];
    logic [7:0] pmask [2];
    logic [7:0] m_es [2];
    logic [7:0] m_ps [2];
    logic [2:0] h_idx [2];
    logic       h_eve [2];
    logic       h_pol [2];
    item_t      last_item [2];
    item_t      sbq [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            b[i]     = 0;
            m_es[i]  = 8'h00;
            m_ps[i]  = 8'h00;
            h_idx[i] = 3'd0;
            h_eve[i] = 1'b0;
            h_pol[i] = 1'b0;
        end
    endtask

    task automatic check_zero(input int i);
        check_eq($sformatf("rst_zero%0d", i),
                 32'({o_valid[i], o_done[i], o_idx[i], o_eve[i], o_pol[i], o_es[i], o_ps[i]}),
                 32'd0);
    endtask

    // Compare one instance's outputs on the current edge against the model
    task automatic check_outputs(input int i);
        item_t      it;
        logic [1:0] exp_st;
        bit         act;
        exp_st = 2'b00;
        act    = 1'b0;
        if (sbq.size() > 0 && sbq[0].cyc == cyc && sbq[0].inst == i) begin
            it = sbq.pop_front();
            if (it.idle) begin
                exp_st = 2'b01;
            end else begin
                exp_st   = 2'b10;
                act      = 1'b1;
                h_idx[i] = 3'(it.k);
                h_eve[i] = it.eve;
                h_pol[i] = it.pol;
            end
        end
        if (clr) begin
            m_es[i] = 8'h00;
            m_ps[i] = 8'h00;
        end else if (act) begin
            m_es[i][it.k] = m_es[i][it.k] | it.eve;
            m_ps[i][it.k] = m_ps[i][it.k] | it.pol;
        end
        check_eq($sformatf("strobe%0d", i), 32'({o_valid[i], o_done[i]}), 32'(exp_st));
        check_eq($sformatf("sample%0d", i), 32'({o_idx[i], o_eve[i], o_pol[i]}),
                 32'({h_idx[i], h_eve[i], h_pol[i]}));
        check_eq($sformatf("seen%0d", i), 32'({o_es[i], o_ps[i]}), 32'({m_es[i], m_ps[i]}));
        if (o_done[i]) fcount[i]++;
    endtask

    // Advance the Gray model one step; the toggled bit names the driving channel
    task automatic decode(input int i);
        int    n, g0, g1, d, t, nb;
        item_t it;
        n  = nch[i];
        nb = (b[i] + 1) & ((1 << (n + 1)) - 1);
        g0 = b[i] ^ (b[i] >> 1);
        g1 = nb ^ (nb >> 1);
        d  = g0 ^ g1;
        t  = 0;
        for (int j = 0; j <= n; j++) begin
            if (d[j]) t = j;
        end
        b[i]    = nb;
        it.cyc  = cyc + 1;
        it.inst = i;
        it.idle = (t == n);
        it.k    = t;
        if (it.idle) begin
            it.eve = 1'($urandom_range(0, 1));
            it.pol = 1'($urandom_range(0, 1));
        end else begin
            it.eve = emask[i][t];
            it.pol = pmask[i][t];
        end
        rde[i] = it.eve;
        rdp[i] = it.pol;
        last_item[i] = it;
        sbq.push_back(it);
    endtask

    initial begin
        bit clr_armed;
        bit clr_chk;
        int clr_k;
        clr_armed = 1'b1;
        clr_chk   = 1'b0;
        clr_k     = 0;
        emask[0] = 8'h20; pmask[0] = 8'h00;
        emask[1] = 8'h01; pmask[1] = 8'h02;
        model_reset();

        repeat (3) @(posedge clk_master);
        #1;
        check_zero(0);
        check_zero(1);
        @(negedge clk_master);
        #1 rstb = 1'b1;

        for (int a = 1; a <= 900; a++) begin
            @(posedge clk_master);
            cyc++;
            #1;
            check_outputs(0);
            check_outputs(1);

            if (a == 33 || a == 97 || a == 161 || a == 225) begin
                check_eq("ch5_slot", 32'({o_valid[0], o_idx[0], o_eve[0]}), 32'({1'b1, 3'd5, 1'b1}));
            end
            if (a == 256) check_eq("ch5_seen", 32'(o_es[0]), 32'h20);
            if (a == 260) begin
                check_eq("frames8", 32'(fcount[0]), 32'd1);
                check_eq("frames2", 32'(fcount[1]), 32'd64);
            end
            if (clr_chk) begin
                check_eq("clr_wins", 32'(o_es[0][clr_k]), 32'd0);
                clr_chk = 1'b0;
            end

            if (run) begin
                decode(0);
                decode(1);
            end else begin
                rde = 2'($urandom);
                rdp = 2'($urandom);
            end

            if (a == 260) begin
                emask[0] = 8'($urandom); pmask[0] = 8'($urandom);
                emask[1] = 8'($urandom); pmask[1] = 8'($urandom);
            end
            if (a == 700) begin
                emask[0] = 8'hFF; pmask[0] = 8'h0F;
                emask[1] = 8'h03; pmask[1] = 8'h01;
            end

            run = !(a >= 400 && a < 410);
            clr = (a == 450);
            if (a >= 720 && clr_armed && !last_item[0].idle && last_item[0].eve
                && last_item[0].cyc == cyc + 1) begin
                clr       = 1'b1;
                clr_k     = last_item[0].k;
                clr_armed = 1'b0;
                clr_chk   = 1'b1;
            end

            if (a == 780) begin
                // Reset lands after the decode edge but before its capture.
                #1 rstb = 1'b0;
                #1;
                check_zero(0);
                check_zero(1);
                rstb = 1'b1;
                model_reset();
                clr_chk = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
